// File: rtl/tetris_soc_spi_pkg.sv
// Shared definitions for the SPI slave: register addresses, status/control
// bit positions and the transfer state machine encoding.
`timescale 1ns/1ps
package tetris_soc_spi_pkg;

  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  localparam int STAT_SSA  = 9;
  localparam int STAT_E    = 8;
  localparam int STAT_RRDY = 7;
  localparam int STAT_TRDY = 6;
  localparam int STAT_TUE  = 4;
  localparam int STAT_ROE  = 3;

  // Control bits sit at the same positions as the status flags they enable.
  localparam logic [15:0] CTRL_MASK = (16'd1 << STAT_E) | (16'd1 << STAT_RRDY) |
                                      (16'd1 << STAT_TRDY) | (16'd1 << STAT_TUE) |
                                      (16'd1 << STAT_ROE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_t;

endpackage

// File: rtl/tetris_soc_spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall
// pulses derived from the synchronized level.
`timescale 1ns/1ps
module tetris_soc_spi_sync #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the pin through the chain and remember the last synchronized level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {STAGES{RESET_VALUE}};
      prev  <= RESET_VALUE;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign dout = chain[STAGES-1];
  assign rise = dout & ~prev;
  assign fall = ~dout & prev;

endmodule

// File: rtl/tetris_soc_spi_slave.sv
// Mode-0 SPI slave with a CPU register port: rx/tx holding registers,
// status flags with overrun/underrun detection and a maskable interrupt.
`timescale 1ns/1ps
module tetris_soc_spi_slave
  import tetris_soc_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic        spi_select,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_n_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_state_t state, state_next;

  logic [7:0]  tx_shift, rx_shift, tx_holding, rx_holding;
  logic [2:0]  bitcnt;
  logic        tx_primed, reload_pending;
  logic        rrdy, roe, tue, toe;
  logic [15:0] control, status, read_mux;
  logic        rd_prev, wr_prev, rd_strobe, wr_strobe;
  logic        rx_read, tx_write, status_write, control_write;
  logic        do_load, do_sample, do_shift, byte_done;

  tetris_soc_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(SCLK), .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall));

  tetris_soc_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .din(SS_n), .dout(ss_n_s), .rise(ss_rise), .fall(ss_fall));

  tetris_soc_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(MOSI), .dout(mosi_s),
    .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  // One strobe per CPU access, on the first cycle the access is seen.
  assign rd_strobe     = spi_select & ~read_n & ~rd_prev;
  assign wr_strobe     = spi_select & ~write_n & ~wr_prev;
  assign rx_read       = rd_strobe && (mem_addr == ADDR_RXDATA);
  assign tx_write      = wr_strobe && (mem_addr == ADDR_TXDATA);
  assign status_write  = wr_strobe && (mem_addr == ADDR_STATUS);
  assign control_write = wr_strobe && (mem_addr == ADDR_CONTROL);

  // State register for the transfer sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: a select falling edge starts a frame, select high ends it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ss_fall) state_next = LOAD;
      LOAD:    state_next = ss_n_s ? IDLE : SHIFT;
      SHIFT:   if (ss_n_s || ss_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath controls: load at frame start and after each byte, else shift.
  always_comb begin
    do_load   = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    case (state)
      LOAD: do_load = 1'b1;
      SHIFT: begin
        if (!ss_n_s) begin
          do_sample = sclk_rise;
          do_load   = sclk_fall & reload_pending;
          do_shift  = sclk_fall & ~reload_pending;
        end
      end
      default: ;
    endcase
  end

  assign byte_done = do_sample && (bitcnt == 3'd7);

  // Serial shift registers and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_shift       <= 8'h00;
      rx_shift       <= 8'h00;
      bitcnt         <= 3'd0;
      reload_pending <= 1'b0;
    end else begin
      if (state == IDLE || state == LOAD) begin
        bitcnt         <= 3'd0;
        reload_pending <= 1'b0;
      end
      if (do_load) begin
        tx_shift       <= tx_primed ? tx_holding : IDLE_BYTE;
        reload_pending <= 1'b0;
      end else if (do_shift) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
      if (do_sample) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        bitcnt   <= bitcnt + 3'd1;
        if (bitcnt == 3'd7) reload_pending <= 1'b1;
      end
    end
  end

  // Holding registers, flags, control and CPU-side access tracking; sets win over clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_holding <= 8'h00;
      tx_holding <= 8'h00;
      tx_primed  <= 1'b0;
      rrdy       <= 1'b0;
      roe        <= 1'b0;
      tue        <= 1'b0;
      toe        <= 1'b0;
      control    <= 16'h0000;
      rd_prev    <= 1'b0;
      wr_prev    <= 1'b0;
    end else begin
      rd_prev <= spi_select & ~read_n;
      wr_prev <= spi_select & ~write_n;

      if (tx_write && !tx_primed) begin
        tx_holding <= data_from_cpu[7:0];
        tx_primed  <= 1'b1;
      end else if (do_load) begin
        tx_primed <= 1'b0;
      end

      if (byte_done) begin
        rx_holding <= {rx_shift[6:0], mosi_s};
        rrdy       <= 1'b1;
      end else if (rx_read) begin
        rrdy <= 1'b0;
      end

      if (byte_done && rrdy && !rx_read) roe <= 1'b1;
      else if (status_write)             roe <= 1'b0;

      if (do_load && !tx_primed) tue <= 1'b1;
      else if (status_write)     tue <= 1'b0;

      if (tx_write && tx_primed) toe <= 1'b1;
      else if (status_write)     toe <= 1'b0;

      if (control_write) control <= data_from_cpu & CTRL_MASK;
    end
  end

  assign status = {6'b0, ~ss_n_s, roe | tue | toe, rrdy, ~tx_primed, 1'b0, tue, roe, 3'b0};

  // Read data selection for the register port.
  always_comb begin
    read_mux = 16'h0000;
    case (mem_addr)
      ADDR_RXDATA:  read_mux = {8'h00, rx_holding};
      ADDR_STATUS:  read_mux = status;
      ADDR_CONTROL: read_mux = control;
      default:      read_mux = 16'h0000;
    endcase
  end

  // Registered read data and interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_to_cpu <= 16'h0000;
      irq         <= 1'b0;
    end else begin
      if (rd_strobe) data_to_cpu <= read_mux;
      irq <= |(status & control);
    end
  end

  assign MISO          = tx_shift[7];
  assign MISO_oe       = ~ss_n_s;
  assign dataavailable = rrdy;
  assign readyfordata  = ~tx_primed;

endmodule

// File: tb/tb_tetris_soc_spi_slave.sv
// Scoreboarded bench for the SPI slave: a mode-0 master at 2.5 MHz plus a
// register-port driver, checked against a small flag model.
`timescale 1ns/1ps
module tb_tetris_soc_spi_slave;

  localparam int HALF = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        SCLK, SS_n, MOSI;
  logic        MISO, MISO_oe;
  logic        spi_select, read_n, write_n;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu;
  logic        irq, dataavailable, readyfordata;

  int checks = 0;
  int errors = 0;

  logic       m_rrdy, m_roe, m_tue, m_toe, m_primed;
  logic [7:0] m_holding;
  logic [15:0] m_ctrl;
  logic [7:0] exp_miso[$];
  logic [7:0] exp_rx[$];

  tetris_soc_spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .spi_select(spi_select), .mem_addr(mem_addr),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq), .dataavailable(dataavailable),
    .readyfordata(readyfordata));

  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_status();
    return {6'b0, 1'b0, m_roe | m_tue | m_toe, m_rrdy, ~m_primed, 1'b0, m_tue, m_roe, 3'b0};
  endfunction

  task automatic model_reset();
    m_rrdy = 0; m_roe = 0; m_tue = 0; m_toe = 0; m_primed = 0;
    m_holding = 8'h00; m_ctrl = 16'h0000;
    exp_miso.delete(); exp_rx.delete();
  endtask

  task automatic model_load();
    if (m_primed) begin
      exp_miso.push_back(m_holding);
      m_primed = 0;
    end else begin
      exp_miso.push_back(8'h00);
      m_tue = 1;
    end
  endtask

  task automatic reg_write(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    spi_select = 1; mem_addr = addr; write_n = 0; data_from_cpu = data;
    @(negedge clk);
    @(negedge clk);
    spi_select = 0; write_n = 1;
    case (addr)
      3'd1: if (m_primed) m_toe = 1; else begin m_holding = data[7:0]; m_primed = 1; end
      3'd2: begin m_roe = 0; m_tue = 0; m_toe = 0; end
      3'd3: m_ctrl = data & 16'h01D8;
      default: ;
    endcase
  endtask

  task automatic reg_read(input logic [2:0] addr, output logic [15:0] data);
    @(negedge clk);
    spi_select = 1; mem_addr = addr; read_n = 0;
    @(negedge clk);
    @(negedge clk);
    spi_select = 0; read_n = 1;
    data = data_to_cpu;
  endtask

  task automatic read_rx(output logic [15:0] got, output logic [15:0] exp);
    exp = (exp_rx.size() > 0) ? {8'h00, exp_rx[$]} : 16'hDEAD;
    exp_rx.delete();
    m_rrdy = 0;
    reg_read(3'd0, got);
  endtask

  task automatic spi_start();
    SS_n = 0;
    model_load();
    #(HALF);
  endtask

  task automatic spi_stop();
    #(HALF);
    SS_n = 1;
    exp_miso.delete();
    #(HALF);
  endtask

  task automatic spi_bits(input logic [7:0] mosi_byte, input int nbits, output logic [7:0] miso_byte);
    miso_byte = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosi_byte[7-i];
      #(HALF);
      miso_byte[7-i] = MISO;
      SCLK = 1;
      #(HALF);
      SCLK = 0;
    end
    if (nbits == 8) begin
      if (m_rrdy) m_roe = 1;
      m_rrdy = 1;
      exp_rx.push_back(mosi_byte);
      model_load();
    end
  endtask

  task automatic send_byte(input logic [7:0] mosi_byte, input string tag);
    logic [7:0] exp, got;
    exp = (exp_miso.size() > 0) ? exp_miso.pop_front() : 8'hxx;
    spi_bits(mosi_byte, 8, got);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s miso: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [15:0] got;
    reset = 1; SCLK = 0; SS_n = 1; MOSI = 0;
    spi_select = 0; read_n = 1; write_n = 1; mem_addr = 0; data_from_cpu = 0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({MISO, MISO_oe, irq, dataavailable, readyfordata} !== 5'b00001 || data_to_cpu !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b/%h expected 00001/0000",
               {MISO, MISO_oe, irq, dataavailable, readyfordata}, data_to_cpu);
    end
    reset = 0;
    reg_read(3'd2, got);
    checks++;
    if (got !== exp_status()) begin
      errors++; $display("[TB] FAIL reset_status: got %h expected %h", got, exp_status());
    end
  endtask

  task automatic test_basic();
    logic [15:0] got, exp;
    reg_write(3'd2, 16'h0000);
    reg_write(3'd1, 16'h00A5);
    spi_start();
    send_byte(8'h3C, "basic");
    spi_stop();
    checks++;
    if (dataavailable !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_rrdy_set: got %b expected 1", dataavailable);
    end
    read_rx(got, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL basic_rx: got %h expected %h", got, exp);
    end
    checks++;
    if (dataavailable !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_rrdy_clear: got %b expected 0", dataavailable);
    end
    reg_read(3'd2, got);
    checks++;
    if (got !== exp_status()) begin
      errors++; $display("[TB] FAIL basic_status: got %h expected %h", got, exp_status());
    end
  endtask

  task automatic test_underrun();
    logic [15:0] got, exp;
    reg_write(3'd2, 16'h0000);
    reg_write(3'd3, 16'h0010);
    checks++;
    if (irq !== |(exp_status() & m_ctrl)) begin
      errors++; $display("[TB] FAIL underrun_irq_idle: got %b expected %b", irq, |(exp_status() & m_ctrl));
    end
    spi_start();
    send_byte(8'hFF, "underrun");
    spi_stop();
    reg_read(3'd2, got);
    checks++;
    if (got !== exp_status()) begin
      errors++; $display("[TB] FAIL underrun_status: got %h expected %h", got, exp_status());
    end
    checks++;
    if (irq !== |(exp_status() & m_ctrl)) begin
      errors++; $display("[TB] FAIL underrun_irq: got %b expected %b", irq, |(exp_status() & m_ctrl));
    end
    reg_read(3'd3, got);
    checks++;
    if (got !== m_ctrl) begin
      errors++; $display("[TB] FAIL control_read: got %h expected %h", got, m_ctrl);
    end
    read_rx(got, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL underrun_rx: got %h expected %h", got, exp);
    end
    reg_write(3'd3, 16'h0000);
  endtask

  task automatic test_back_to_back();
    logic [15:0] got, exp;
    reg_write(3'd2, 16'h0000);
    spi_start();
    send_byte(8'h11, "b2b_first");
    send_byte(8'h22, "b2b_second");
    spi_stop();
    reg_read(3'd2, got);
    checks++;
    if (got !== exp_status()) begin
      errors++; $display("[TB] FAIL overrun_status: got %h expected %h", got, exp_status());
    end
    read_rx(got, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL overrun_rx: got %h expected %h", got, exp);
    end
    reg_write(3'd2, 16'h0000);
    reg_read(3'd2, got);
    checks++;
    if (got !== exp_status()) begin
      errors++; $display("[TB] FAIL overrun_cleared: got %h expected %h", got, exp_status());
    end
  endtask

  task automatic test_tx_overflow();
    logic [15:0] got, exp;
    reg_write(3'd2, 16'h0000);
    reg_write(3'd1, 16'h005A);
    reg_write(3'd1, 16'h0077);
    reg_read(3'd2, got);
    checks++;
    if (got !== exp_status()) begin
      errors++; $display("[TB] FAIL toe_status: got %h expected %h", got, exp_status());
    end
    spi_start();
    send_byte(8'h00, "toe_tx");
    spi_stop();
    read_rx(got, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL toe_rx: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_abort();
    logic [15:0] got, exp;
    logic [7:0]  partial;
    reg_write(3'd2, 16'h0000);
    spi_start();
    void'(exp_miso.pop_front());
    spi_bits(8'hF0, 4, partial);
    spi_stop();
    checks++;
    if (dataavailable !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_rrdy: got %b expected 0", dataavailable);
    end
    reg_write(3'd1, 16'h00C6);
    spi_start();
    send_byte(8'h81, "abort_next");
    spi_stop();
    read_rx(got, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL abort_rx: got %h expected %h", got, exp);
    end
    reg_read(3'd2, got);
    checks++;
    if (got !== exp_status()) begin
      errors++; $display("[TB] FAIL abort_status: got %h expected %h", got, exp_status());
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got, exp;
    logic [7:0]  partial;
    reg_write(3'd1, 16'h003C);
    spi_start();
    void'(exp_miso.pop_front());
    spi_bits(8'hAA, 4, partial);
    reset = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({MISO, MISO_oe, irq, dataavailable, readyfordata} !== 5'b00001 || data_to_cpu !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %b/%h expected 00001/0000",
               {MISO, MISO_oe, irq, dataavailable, readyfordata}, data_to_cpu);
    end
    SS_n = 1; MOSI = 0;
    @(negedge clk);
    reset = 0;
    model_reset();
    reg_write(3'd1, 16'h00C3);
    spi_start();
    send_byte(8'h96, "midreset_next");
    spi_stop();
    read_rx(got, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL midreset_rx: got %h expected %h", got, exp);
    end
    reg_read(3'd2, got);
    checks++;
    if (got !== exp_status()) begin
      errors++; $display("[TB] FAIL midreset_status: got %h expected %h", got, exp_status());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_tx_overflow();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tetris_soc_spi_slave.md
TETRIS_SOC_SPI_SLAVE -- requirements
Module: tetris_soc_spi_slave

Interface
REQ-001 Parameters SHALL be:
- SYNC_STAGES, 2, synchronizer depth on SCLK/SS_n/MOSI.
- IDLE_BYTE, 8'h00, byte shifted out on tx underrun.
REQ-002 Timing: one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be:
- clk  in  1  system clock, 50 MHz
- reset  in  1  async active-high reset
- SCLK  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0)
- SS_n  in  1  slave select, active low
- MOSI  in  1  serial data from master, MSB first
- MISO  out  1  serial data to master
- MISO_oe  out  1  MISO driver enable
- spi_select  in  1  register-port chip select
- mem_addr  in  3  register address
- read_n  in  1  active-low read
- write_n  in  1  active-low write
- data_from_cpu  in  16  write data
- data_to_cpu  out  16  registered read data
- irq  out  1  interrupt
- dataavailable  out  1  equals RRDY
- readyfordata  out  1  equals TRDY

Function
REQ-004 Register map SHALL be: 0 rx data (r), 1 tx data (w), 2 status (r; write clears flags), 3 control (r/w irq enables); other addresses read 0.
REQ-005 Reads and writes SHALL be two-cycle events; strobe fires once per access; data_to_cpu registered one cycle after address.
REQ-006 Status SHALL be {SSA[9], E[8], RRDY[7], TRDY[6], 1'b0[5], TUE[4], ROE[3], 3'b0}, E = ROE|TUE|TOE, with TOE reported in E only.
REQ-007 Control bits 8,7,6,4,3 SHALL enable irq for E, RRDY, TRDY, TUE, ROE. irq SHALL be registered as OR of enabled flags.
REQ-008 SCLK, SS_n and MOSI SHALL pass through SYNC_STAGES flops; edges SHALL be detected on synchronized SCLK.
REQ-009 Supported SCLK SHALL be at most clk/8.
REQ-010 State machine SHALL have states IDLE, LOAD, SHIFT.
- IDLE -> LOAD on synchronized SS_n falling.
- LOAD, one cycle: shift_reg <= tx_holding if primed, else IDLE_BYTE with TUE set; tx_holding_primed cleared; bitcnt <= 0; then SHIFT.
- SHIFT: SCLK rising samples MOSI into rx shift, bitcnt+1. SCLK falling shifts tx left.
- After 8th rising edge (bitcnt wraps 7->0): rx_holding <= byte, RRDY <= 1, ROE <= 1 if RRDY was already 1; next falling edge reloads tx as in LOAD.
- SHIFT -> IDLE on SS_n rising at any point.
REQ-011 MISO SHALL equal tx shift_reg[7]; MISO_oe SHALL equal synchronized ~SS_n.
REQ-012 TRDY SHALL be ~tx_holding_primed. Tx write with TRDY=1 loads the low 8 bits and primes. Tx write with TRDY=0 sets TOE and drops the data.
REQ-013 Rx data read SHALL clear RRDY.
REQ-014 Simultaneous rx read and byte completion: RRDY stays 1, ROE not set, new byte visible on next read.
REQ-015 Simultaneous status write and flag set: set wins.
REQ-016 SS_n deassert mid-byte SHALL discard the partial byte: no RRDY, bitcnt reset, tx_holding unaffected if not yet loaded.
REQ-017 SSA SHALL equal synchronized ~SS_n.

Reset
REQ-018 Reset SHALL clear all flags, registers, shift registers and irq enables. State SHALL be IDLE.
REQ-019 Reset values: MISO=0, MISO_oe=0, irq=0, data_to_cpu=0, dataavailable=0, readyfordata=1. Synchronizer flops reset to SS_n=1, SCLK=0.
REQ-020 Reset mid-transfer SHALL abort the transfer. After release, the block waits in IDLE for a fresh SS_n falling edge.

Structure
REQ-021 Package tetris_soc_spi_pkg SHALL hold register addresses, status/control bit indices and the state enum.
REQ-022 Sub-module tetris_soc_spi_sync SHALL implement the synchronizer plus rise/fall detect, instantiated three times (edge outputs unused for MOSI).

Verification
REQ-023 The bench SHALL cover:
- Prime tx=8'hA5; master sends 8'h3C at 2.5 MHz -> MISO bits 1,0,1,0,0,1,0,1; rx reads 16'h003C; RRDY 1 then 0 after read.
- No tx primed; master sends 8'hFF -> MISO shifts 8'h00; TUE=1; irq=1 with control bit 4 set.
- Two bytes 8'h11, 8'h22 without rx read -> ROE=1; rx reads 8'h22; status write clears ROE.
- Tx write twice without transfer -> TOE=1, E=1; first byte 8'h5A transmitted.
- SS_n rises after 4 bits -> RRDY stays 0; next full byte 8'h81 received correctly.
- Reset asserted mid-byte -> all outputs at reset values; subsequent transfer correct.
